// File: rtl/div_pkg.sv
// Shared types and helpers for the divider post-processing stage.
// Optional feature macro: DIV_ROUND_EN (round-to-nearest of the quotient).
package div_pkg;

    localparam int DIV_WN = 8;   // numerator / quotient width
    localparam int DIV_WD = 6;   // denominator / remainder width

    // One queued divider result.
    typedef struct packed {
        logic [DIV_WN-1:0] q;
        logic [DIV_WD-1:0] r;
        logic              dz;
    } div_res_t;

`ifdef DIV_ROUND_EN
    // Half-up rounding of an unsigned quotient; the compare is done one bit
    // wider than the remainder so 2*r cannot wrap. Saturates at all ones.
    function automatic logic [DIV_WN-1:0] div_round(
        input logic [DIV_WN-1:0] q,
        input logic [DIV_WD-1:0] r,
        input logic [DIV_WD-1:0] d
    );
        logic [DIV_WD:0] r2;
        logic [DIV_WD:0] dd;
        r2 = {r, 1'b0};
        dd = {1'b0, d};
        if ((r2 >= dd) && (q != {DIV_WN{1'b1}})) begin
            return q + {{(DIV_WN-1){1'b0}}, 1'b1};
        end else begin
            return q;
        end
    endfunction
`endif

endpackage

// File: rtl/div_post_if.sv
// Consumer-side valid/ready result bus of div_post.
interface div_post_if #(
    parameter int WN = 8,
    parameter int WD = 6
);
    logic          m_valid;
    logic          m_ready;
    logic [WN-1:0] m_q;
    logic [WD-1:0] m_r;
    logic          m_dz;

    modport master (
        output m_valid,
        output m_q,
        output m_r,
        output m_dz,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_q,
        input  m_r,
        input  m_dz,
        output m_ready
    );
endinterface

// File: rtl/div_post_fifo.sv
// First-word-fall-through FIFO of result records. Pointers carry one extra
// bit so full and empty can be told apart when the index bits are equal.
module div_post_fifo
    import div_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type rec_t = div_res_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  rec_t                   wdata,
    input  logic                   pop,
    output rec_t                   rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    rec_t        mem_r [DEPTH];
    logic        pop_ok_s;
    logic        push_ok_s;

    assign empty = (wr_ptr_r == rd_ptr_r);
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign level = wr_ptr_r - rd_ptr_r;
    assign rdata = mem_r[rd_ptr_r[AW-1:0]];

    // Qualify requests: a pop needs data, a push needs room or a same-cycle pop.
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && !empty) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && (!full || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Storage and pointer update; reset clears everything so the head reads zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= wdata;
                wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/div_post.sv
// Divider result post-processing: captures quotient/remainder on the result
// strobe, flags divide-by-zero, optionally rounds, and buffers results in a
// FWFT FIFO toward a valid/ready consumer. Dropped results set sticky ovf.
// Optional feature macro: DIV_ROUND_EN.
module div_post
    import div_pkg::*;
#(
    parameter int WN    = DIV_WN,
    parameter int WD    = DIV_WD,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   res_valid,
    input  logic [WN-1:0]          q_in,
    input  logic [WD-1:0]          r_in,
    input  logic [WD-1:0]          d_in,
    div_post_if.master             m_if,
    output logic                   ovf,
    output logic [$clog2(DEPTH):0] level
);

    typedef struct packed {
        logic [WN-1:0] q;
        logic [WD-1:0] r;
        logic          dz;
    } rec_t;

    rec_t s1_next_s;
    rec_t s1_rec_r;
    logic s1_valid_r;
    rec_t head_s;
    logic full_s;
    logic empty_s;
    logic pop_s;
    logic accept_s;
    logic push_s;
    logic ovf_r;

    // Build the stage-1 record from the raw divider outputs.
    always_comb begin
        s1_next_s = '0;
        if (d_in == {WD{1'b0}}) begin
            s1_next_s.q  = {WN{1'b1}};
            s1_next_s.r  = {WD{1'b0}};
            s1_next_s.dz = 1'b1;
        end else begin
`ifdef DIV_ROUND_EN
            s1_next_s.q  = div_round(q_in, r_in, d_in);
`else
            s1_next_s.q  = q_in;
`endif
            s1_next_s.r  = r_in;
            s1_next_s.dz = 1'b0;
        end
    end

    // Stage-1 register: holds one result for a cycle before it enters the FIFO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid_r <= 1'b0;
            s1_rec_r   <= '0;
        end else begin
            s1_valid_r <= res_valid;
            if (res_valid) begin
                s1_rec_r <= s1_next_s;
            end
        end
    end

    // Handshake glue: a full FIFO still takes a push when the head leaves this cycle.
    always_comb begin
        pop_s    = 1'b0;
        accept_s = 1'b0;
        push_s   = 1'b0;
        if (!empty_s && m_if.m_ready) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
        accept_s = !full_s || pop_s;
        if (s1_valid_r && accept_s) begin
            push_s = 1'b1;
        end else begin
            push_s = 1'b0;
        end
    end

    // Sticky overflow: set whenever a stage-1 result is refused.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else if (s1_valid_r && !accept_s) begin
            ovf_r <= 1'b1;
        end
    end

    div_post_fifo #(
        .DEPTH (DEPTH),
        .rec_t (rec_t)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .wdata (s1_rec_r),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .level (level)
    );

    assign m_if.m_valid = !empty_s;
    assign m_if.m_q     = head_s.q;
    assign m_if.m_r     = head_s.r;
    assign m_if.m_dz    = head_s.dz;
    assign ovf          = ovf_r;

endmodule
